// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - four-entry nibble sorter sharing one comparator over a six-step bubble schedule
module sort4_ctrl #(
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic [2:0] swap_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] r0_q, r0_d;
    logic [3:0] r1_q, r1_d;
    logic [3:0] r2_q, r2_d;
    logic [3:0] r3_q, r3_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] step_q, step_d;
    logic [2:0] swap_q, swap_d;

    logic [3:0] cmp_l;
    logic [3:0] cmp_r;
    logic       do_swap;
    logic [3:0] sel_data;

    // Pair schedule: steps 0,3,5 -> (r0,r1); steps 1,4 -> (r1,r2); step 2 -> (r2,r3)
    always_comb begin
        cmp_l = r0_q;
        cmp_r = r1_q;
        case (step_q)
            3'd1, 3'd4: begin
                cmp_l = r1_q;
                cmp_r = r2_q;
            end
            3'd2: begin
                cmp_l = r2_q;
                cmp_r = r3_q;
            end
            default: begin
                cmp_l = r0_q;
                cmp_r = r1_q;
            end
        endcase
    end

    // Equal operands never swap in either direction
    assign do_swap = DESCEND ? (cmp_l < cmp_r) : (cmp_l > cmp_r);

    always_comb begin
        case (idx_q)
            2'd0:    sel_data = r0_q;
            2'd1:    sel_data = r1_q;
            2'd2:    sel_data = r2_q;
            default: sel_data = r3_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        idx_d     = idx_q;
        step_d    = step_q;
        swap_d    = swap_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 4'd0;
        out_last  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (idx_q)
                        2'd0:    r0_d = in_data;
                        2'd1:    r1_d = in_data;
                        2'd2:    r2_d = in_data;
                        default: r3_d = in_data;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_SORT;
                        step_d  = 3'd0;
                        idx_d   = 2'd0;
                    end
                end
            end

            ST_SORT: begin
                if (do_swap) begin
                    swap_d = swap_q + 3'd1;
                    case (step_q)
                        3'd1, 3'd4: begin
                            r1_d = r2_q;
                            r2_d = r1_q;
                        end
                        3'd2: begin
                            r2_d = r3_q;
                            r3_d = r2_q;
                        end
                        default: begin
                            r0_d = r1_q;
                            r1_d = r0_q;
                        end
                    endcase
                end
                if (step_q == 3'd5) begin
                    state_d = ST_DRAIN;
                    step_d  = 3'd0;
                    idx_d   = 2'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end

            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = sel_data;
                out_last  = (idx_q == 2'd3);
                if (out_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_LOAD;
                        idx_d   = 2'd0;
                        swap_d  = 3'd0;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
                idx_d   = 2'd0;
                step_d  = 3'd0;
                swap_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            r0_q    <= 4'd0;
            r1_q    <= 4'd0;
            r2_q    <= 4'd0;
            r3_q    <= 4'd0;
            idx_q   <= 2'd0;
            step_q  <= 3'd0;
            swap_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            swap_q  <= swap_d;
        end
    end

    assign busy     = (state_q == ST_SORT) || (state_q == ST_DRAIN);
    assign swap_cnt = swap_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
// tb/tb_sort4_ctrl.sv - directed-vector bench for sort4_ctrl in both sort directions
module tb_sort4_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [3:0] a_out_data;
    logic [2:0] a_swap_cnt;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [3:0] d_out_data;
    logic [2:0] d_swap_cnt;

    sort4_ctrl #(.DESCEND(1'b0)) dut_asc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_last  (a_out_last),
        .busy      (a_busy),
        .swap_cnt  (a_swap_cnt)
    );

    sort4_ctrl #(.DESCEND(1'b1)) dut_desc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready),
        .out_data  (d_out_data),
        .out_valid (d_out_valid),
        .out_ready (out_ready),
        .out_last  (d_out_last),
        .busy      (d_busy),
        .swap_cnt  (d_swap_cnt)
    );

    // Both instances run in lockstep; sel picks which one is observed
    logic       sel;
    logic [3:0] o_data;
    logic       o_valid, o_last, o_inready, o_busy;
    logic [2:0] o_swap;
    assign o_data    = sel ? d_out_data  : a_out_data;
    assign o_valid   = sel ? d_out_valid : a_out_valid;
    assign o_last    = sel ? d_out_last  : a_out_last;
    assign o_inready = sel ? d_in_ready  : a_in_ready;
    assign o_busy    = sel ? d_busy      : a_busy;
    assign o_swap    = sel ? d_swap_cnt  : a_swap_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_set(input logic [15:0] vals, input bit gaps, output int cycles);
        int  k;
        int  n;
        bit  acc;
        k = 0;
        n = 0;
        while (k < 4 && n < 64) begin
            in_data  = vals[15-4*k -: 4];
            in_valid = gaps ? n[0] : 1'b1;
            acc      = in_valid && o_inready;
            @(negedge clk);
            n++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        cycles   = n;
        chk("load_beats", 16'(k), 16'd4);
    endtask

    task automatic check_sort_latency();
        int lat;
        chk("sort_busy", 16'(o_busy), 16'd1);
        chk("sort_in_ready", 16'(o_inready), 16'd0);
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("out_latency", 16'(lat), 16'd7);
    endtask

    task automatic drain(input logic [15:0] exp, input logic [2:0] swaps, input logic [3:0] stall);
        int n;
        logic [3:0] e;
        for (int j = 0; j < 4; j++) begin
            e = exp[15-4*j -: 4];
            n = 0;
            while (!o_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("out_valid", 16'(o_valid), 16'd1);
            if (stall[j]) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("stall_data", 16'(o_data), 16'(e));
                    chk("stall_last", 16'(o_last), 16'(j == 3));
                    chk("stall_in_ready", 16'(o_inready), 16'd0);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            chk("out_data", 16'(o_data), 16'(e));
            chk("out_last", 16'(o_last), 16'(j == 3));
            chk("swap_cnt", 16'(o_swap), 16'(swaps));
            chk("drain_in_ready", 16'(o_inready), 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("post_valid", 16'(o_valid), 16'd0);
        chk("post_in_ready", 16'(o_inready), 16'd1);
        chk("post_swap", 16'(o_swap), 16'd0);
    endtask

    task automatic run_set(input logic [15:0] vals, input logic [15:0] exp,
                           input logic [2:0] swaps, input logic [3:0] stall);
        int cyc;
        send_set(vals, 1'b0, cyc);
        chk("load_cycles", 16'(cyc), 16'd4);
        check_sort_latency();
        drain(exp, swaps, stall);
    endtask

    initial begin
        int cyc;
        sel       = 1'b0;
        rst_n     = 1'b1;
        in_data   = 4'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset asserted mid-cycle
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 16'(o_inready), 16'd1);
        chk("rst_out_valid", 16'(o_valid), 16'd0);
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_swap", 16'(o_swap), 16'd0);
        chk("rst_out_data", 16'(o_data), 16'd0);
        chk("rst_out_last", 16'(o_last), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_set(16'h93F0, 16'h039F, 3'd4, 4'b0000);
        run_set(16'h1234, 16'h1234, 3'd0, 4'b0000);
        run_set(16'hFA50, 16'h05AF, 3'd6, 4'b0000);
        run_set(16'h7777, 16'h7777, 3'd0, 4'b0000);

        // Backpressure on first and third beats
        run_set(16'h93F0, 16'h039F, 3'd4, 4'b0101);

        // Reset during SORT step 3
        send_set(16'h93F0, 1'b0, cyc);
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 16'(o_busy), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(o_valid), 16'd0);
        chk("mid_rst_busy", 16'(o_busy), 16'd0);
        chk("mid_rst_in_ready", 16'(o_inready), 16'd1);
        chk("mid_rst_swap", 16'(o_swap), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_set(16'h2103, 16'h0123, 3'd3, 4'b0000);

        // Descending instance with in_valid toggling every cycle
        sel = 1'b1;
        send_set(16'h93F0, 1'b1, cyc);
        chk("gap_cycles", 16'(cyc), 16'd8);
        check_sort_latency();
        drain(16'hF930, 3'd2, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
